seq_detect_ctrl: RTL



---
 rtl/seq_detect_pkg.sv | 22 ++
 rtl/seq_detect_ctrl_matcher.sv | 52 +++++
 rtl/seq_detect_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared state encoding and configuration record for the serial pattern detector.
// Config fields are sized for the largest supported pattern so every instance can share one type.
package seq_detect_pkg;

    localparam int PAT_W = 16;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int TGT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PAT_W-1:0] pattern;
        logic [LEN_W-1:0] len;
        logic             overlap;
        logic [TGT_W-1:0] target;
    } cfg_t;

endpackage

// File: rtl/seq_detect_ctrl_matcher.sv
// seq_matcher: shift-register history plus fill count with a combinational compare against the pattern.
// match reflects the post-shift state in the same cycle; no backpressure, one bit per shift.
module seq_matcher
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_upd;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_upd;
    logic [PAT_W-1:0]   hist_ext, len_mask;

    always_comb begin
        hist_upd = hist_q;
        fill_upd = fill_q;
        if (shift) begin
            hist_upd = {hist_q[MAX_LEN-2:0], bit_in};
            if (fill_q < len) begin
                fill_upd = fill_q + LEN_W'(1);
            end
        end
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len));
        end
        hist_ext = PAT_W'(hist_upd);
        match    = shift && (fill_upd == len) && (((hist_ext ^ pattern) & len_mask) == '0);
        // Without overlap the next match must be built from entirely fresh bits.
        hist_d = clear ? '0 : hist_upd;
        fill_d = (clear || (match && !overlap)) ? '0 : fill_upd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: valid/ready config, start/stop arming, match counting; outputs registered, 1-cycle latency.
// cfg_ready only in IDLE; serial input has no backpressure. Optional idle timeout under SEQ_CTRL_TIMEOUT_EN.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN        = 8,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         a_valid,
    input  logic                         a,
    output logic                         detected,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         timeout
);

    localparam int CFG_LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [CFG_LEN_W-1:0] MAX_LEN_V = CFG_LEN_W'(MAX_LEN);

    state_t           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic             cfg_loaded_q, cfg_loaded_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             detected_q, detected_d, done_q, done_d, err_q, err_d;
    logic             timeout_q, timeout_d, busy_q, busy_d, cfg_ready_q, cfg_ready_d;
    logic             shift, clear, match, len_ok;

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    seq_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .clear   (clear),
        .bit_in  (a),
        .pattern (cfg_q.pattern),
        .len     (cfg_q.len),
        .overlap (cfg_q.overlap),
        .match   (match)
    );

    assign len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        cfg_loaded_d = cfg_loaded_q;
        match_cnt_d  = match_cnt_q;
        detected_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        timeout_d    = 1'b0;
        shift        = 1'b0;
        clear        = 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
        tmr_d        = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                // A config beat wins over a same-cycle start, which is silently dropped.
                if (cfg_valid) begin
                    if (len_ok) begin
                        cfg_d.pattern = PAT_W'(cfg_pattern);
                        cfg_d.len     = LEN_W'(cfg_len);
                        cfg_d.overlap = cfg_overlap;
                        cfg_d.target  = TGT_W'(cfg_target);
                        cfg_loaded_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start) begin
                    if (cfg_loaded_q) begin
                        state_d     = ARMED;
                        clear       = 1'b1;
                        match_cnt_d = '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
                        tmr_d       = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    err_d = start;
                    shift = a_valid;
`ifdef SEQ_CTRL_TIMEOUT_EN
                    tmr_d = tmr_q + TMR_W'(1);
`endif
                    if (match) begin
                        detected_d = 1'b1;
                        if (match_cnt_q != '1) begin
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                        end
`ifdef SEQ_CTRL_TIMEOUT_EN
                        tmr_d = '0;
`endif
                        if ((cfg_q.target != '0) && (TGT_W'(match_cnt_d) == cfg_q.target)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
`ifdef SEQ_CTRL_TIMEOUT_EN
                    if ((state_d == ARMED) && (tmr_d == TMR_LIMIT)) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = ARMED;
                    clear       = 1'b1;
                    match_cnt_d = '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
                    tmr_d       = '0;
`endif
                end else if (stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            cfg_loaded_q <= 1'b0;
            match_cnt_q  <= '0;
            detected_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            cfg_loaded_q <= cfg_loaded_d;
            match_cnt_q  <= match_cnt_d;
            detected_q   <= detected_d;
            done_q       <= done_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

`ifdef SEQ_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    assign cfg_ready = cfg_ready_q;
    assign detected  = detected_q;
    assign match_cnt = match_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign timeout   = timeout_q;

endmodule
